// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state codes, register
// offsets, vector width and a highest-set-bit helper.
package irq_pkg;

  localparam int unsigned VEC_W   = 8;
  // Widest vector max_index() accepts; narrower vectors are zero-extended.
  localparam int unsigned MAX_SRC = 32;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;

  localparam logic [13:0] MASK_OFS   = 14'd0;
  localparam logic [13:0] EOI_OFS    = 14'd2;
  localparam logic [13:0] STATUS_OFS = 14'd4;

  // Index of the highest set bit; 0 for an all-zero vector, so qualify with |v.
  function automatic logic [VEC_W-1:0] max_index(input logic [MAX_SRC-1:0] v);
    logic [VEC_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (v[i]) idx = VEC_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Highest-index request encoder. Only requests strictly above the in-service
// threshold compete; with no threshold every request competes.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic               thr_valid,
  input  logic [VEC_W-1:0]   thr,
  output logic [VEC_W-1:0]   idx,
  output logic               any_valid
);

  // Later (higher) indices overwrite earlier ones, leaving the highest winner.
  always_comb begin
    idx       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i] && (!thr_valid || (VEC_W'(i) > thr))) begin
        idx       = VEC_W'(i);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: samples active-low device requests, applies MASK and
// in-service tracking, and runs the int_n / int_ack_n handshake with the CPU.
// Optional macro IRQ_EDGE_EN switches request detection from level-sensitive
// to per-source falling-edge latches.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter logic [13:0] BASE_ADDR   = 14'h2000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_n,
  input  logic               int_ack_n,
  output logic               int_n,
  output logic [VEC_W-1:0]   vector,
  output logic               vector_valid,
  input  logic [13:0]        addr_bus,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [15:0]        wdata,
  output logic [15:0]        rdata
);

  localparam int unsigned IdxW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [13:0] MaskAddr   = BASE_ADDR + MASK_OFS;
  localparam logic [13:0] EoiAddr    = BASE_ADDR + EOI_OFS;
  localparam logic [13:0] StatusAddr = BASE_ADDR + STATUS_OFS;

  logic [NUM_SRC-1:0] irq_s_q, mask_q, mask_d, isr_q, isr_d, pend;
  logic [NUM_SRC-1:0] eoi_clr, set_isr;
  logic [1:0]         state_q, state_d;
  logic [VEC_W-1:0]   sel_q, sel_d, vector_q, vector_d, win_idx, isr_top;
  logic [15:0]        cnt_q, cnt_d, cnt_inc, rdata_q, rdata_d;
  logic               int_n_q, int_n_d, vv_q, vv_d, win_valid;
  logic               unused_wdata;

  assign unused_wdata = ^wdata;

`ifdef IRQ_EDGE_EN
  logic [NUM_SRC-1:0] lat_q, lat_d;
  assign pend = lat_q & mask_q;
  // A fresh falling edge during ACK for sel survives the clear.
  assign lat_d = (lat_q & ~set_isr) | (irq_s_q & ~irq_n);
`else
  assign pend = ~irq_s_q & mask_q;
`endif

  assign isr_top = max_index(MAX_SRC'(isr_q));

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req       (pend),
    .thr_valid (|isr_q),
    .thr       (isr_top),
    .idx       (win_idx),
    .any_valid (win_valid)
  );

  // Register file: MASK write, EOI clear decode, registered read mux (pre-write data).
  always_comb begin
    mask_d  = mask_q;
    eoi_clr = '0;
    rdata_d = '0;
    if (!wr_n && (addr_bus == MaskAddr)) mask_d = wdata[NUM_SRC-1:0];
    // Indices at or above NUM_SRC shift out and clear nothing.
    if (!wr_n && (addr_bus == EoiAddr)) eoi_clr = NUM_SRC'(1'b1) << wdata[IdxW-1:0];
    if (!rd_n) begin
      if (addr_bus == MaskAddr) begin
        rdata_d = 16'(mask_q);
      end else if (addr_bus == StatusAddr) begin
        rdata_d = {8'(isr_q), 8'(pend)};
      end
    end
  end

  // Handshake FSM: arbitrate in IDLE, hold sel through REQ, strobe vector in ACK.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + 16'd1;
    int_n_d  = int_n_q;
    vector_d = vector_q;
    vv_d     = 1'b0;
    set_isr  = '0;
    case (state_q)
      StIdle: begin
        if (win_valid) begin
          sel_d   = win_idx;
          int_n_d = 1'b0;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (!int_ack_n) begin
          int_n_d  = 1'b1;
          vector_d = sel_q;
          vv_d     = 1'b1;
          state_d  = StAck;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == 16'(ACK_TIMEOUT)) begin
            int_n_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StAck: begin
        set_isr = NUM_SRC'(1'b1) << sel_q;
        state_d = StIdle;
      end
      default: begin
        int_n_d = 1'b1;
        state_d = StIdle;
      end
    endcase
    // Set after clear so an ACK for the EOI'd index keeps the bit.
    isr_d = (isr_q & ~eoi_clr) | set_isr;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_s_q  <= '1;
      mask_q   <= '1;
      isr_q    <= '0;
      state_q  <= StIdle;
      sel_q    <= '0;
      cnt_q    <= '0;
      int_n_q  <= 1'b1;
      vector_q <= '0;
      vv_q     <= 1'b0;
      rdata_q  <= '0;
`ifdef IRQ_EDGE_EN
      lat_q    <= '0;
`endif
    end else begin
      irq_s_q  <= irq_n;
      mask_q   <= mask_d;
      isr_q    <= isr_d;
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      int_n_q  <= int_n_d;
      vector_q <= vector_d;
      vv_q     <= vv_d;
      rdata_q  <= rdata_d;
`ifdef IRQ_EDGE_EN
      lat_q    <= lat_d;
`endif
    end
  end

  assign int_n        = int_n_q;
  assign vector       = vector_q;
  assign vector_valid = vv_q;
  assign rdata        = rdata_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model of pending/in-service sources.
module tb_irq_arbiter;

  localparam int unsigned NumSrc     = 8;
  localparam logic [13:0] Base       = 14'h2000;
  localparam int unsigned AckTimeout = 255;
  localparam logic [13:0] AMask      = Base;
  localparam logic [13:0] AEoi       = Base + 14'd2;
  localparam logic [13:0] AStatus    = Base + 14'd4;
  localparam logic [13:0] AUnmapped  = Base + 14'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_n;
  logic        int_ack_n;
  logic        int_n;
  logic [7:0]  vector;
  logic        vector_valid;
  logic [13:0] addr_bus;
  logic        rd_n;
  logic        wr_n;
  logic [15:0] wdata;
  logic [15:0] rdata;

  irq_arbiter #(
    .NUM_SRC     (NumSrc),
    .BASE_ADDR   (Base),
    .ACK_TIMEOUT (AckTimeout)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_n        (irq_n),
    .int_ack_n    (int_ack_n),
    .int_n        (int_n),
    .vector       (vector),
    .vector_valid (vector_valid),
    .addr_bus     (addr_bus),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .wdata        (wdata),
    .rdata        (rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what software and devices have done, not how the RTL does it.
  logic [7:0] m_irq;   // request pins as driven
  logic [7:0] m_mask;
  logic [7:0] m_isr;   // sources acknowledged and not yet EOI'd
  logic [7:0] m_lat;   // falling edges seen and not yet acknowledged

  function automatic bit model_pend(input int i);
`ifdef IRQ_EDGE_EN
    return m_lat[i] && m_mask[i];
`else
    return !m_irq[i] && m_mask[i];
`endif
  endfunction

  // Highest pending source strictly above every in-service source, or -1.
  function automatic int model_winner();
    int top = -1;
    int w   = -1;
    for (int i = 0; i < 8; i++) if (m_isr[i]) top = i;
    for (int i = 0; i < 8; i++) if (model_pend(i) && i > top) w = i;
    return w;
  endfunction

  function automatic logic [15:0] model_status();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = model_pend(i);
    return {m_isr, p};
  endfunction

  task automatic set_irq(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (m_irq[i] && !v[i]) m_lat[i] = 1'b1;
    m_irq = v;
    irq_n = v;
  endtask

  task automatic reset_dut();
    irq_n = 8'hFF; int_ack_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr_bus = '0; wdata = '0;
    m_irq = 8'hFF; m_mask = 8'hFF; m_isr = '0; m_lat = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [15:0] d);
    addr_bus = a; wdata = d; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    if (a == AMask) m_mask = d[7:0];
    else if (a == AEoi) m_isr[d[2:0]] = 1'b0;
  endtask

  task automatic bus_read(input logic [13:0] a, output logic [15:0] d);
    addr_bus = a; rd_n = 1'b0;
    @(negedge clk);
    rd_n = 1'b1;
    d = rdata;
  endtask

  task automatic wait_int(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      if (int_n === 1'b0) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  // Wait for int_n, acknowledge after 'delay' cycles, check the vector strobe.
  task automatic service(input int exp, input int delay, input string tag);
    bit ok;
    wait_int(20, ok);
    check({tag, "_int_low"}, 32'(ok), 32'd1);
    if (!ok) return;
    repeat (delay) @(negedge clk);
    int_ack_n = 1'b0;
    @(negedge clk);
    int_ack_n = 1'b1;
    check({tag, "_vv"}, 32'(vector_valid), 32'd1);
    check({tag, "_vec"}, 32'(vector), 32'(exp));
    @(negedge clk);
    check({tag, "_vv_drop"}, 32'(vector_valid), 32'd0);
    m_isr[exp] = 1'b1;
    m_lat[exp] = 1'b0;
  endtask

  task automatic quiet(input int n, input string tag);
    bit seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (int_n !== 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    bit          ok;
    int          n;

    // Reset state and MASK default.
    reset_dut();
    check("rst_int_n", 32'(int_n), 32'd1);
    check("rst_vv", 32'(vector_valid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    bus_read(AMask, d);   check("rst_mask", 32'(d), 32'h00FF);
    bus_read(AStatus, d); check("rst_status", 32'(d), 32'h0000);

    // Single source, late ack, EOI with source still held.
    set_irq(8'hFB);
    service(2, 3, "s2");
    bus_read(AStatus, d);
`ifdef IRQ_EDGE_EN
    check("s2_status", 32'(d), 32'h0400);
`else
    check("s2_status", 32'(d), 32'h0404);
`endif
    bus_write(AEoi, 16'd2);
    bus_read(AStatus, d);
`ifdef IRQ_EDGE_EN
    check("s2_status_eoi", 32'(d), 32'h0000);
`else
    check("s2_status_eoi", 32'(d), 32'h0004);
`endif

    // Two sources: highest first, lower only after EOI of the higher.
    reset_dut();
    set_irq(8'h7E);
    service(7, 1, "s3a");
    set_irq(8'hFE);
    bus_write(AEoi, 16'd7);
    service(0, 2, "s3b");

    // In-service 5 blocks 3; 6 nests above it.
    reset_dut();
    set_irq(8'hDF);
    service(5, 0, "s4a");
    set_irq(8'hF7);
    quiet(6, "s4_blocked");
    set_irq(8'hB7);
    service(6, 2, "s4b");
    bus_read(AStatus, d);
`ifdef IRQ_EDGE_EN
    check("s4_status", 32'(d), 32'h6008);
`else
    check("s4_status", 32'(d), 32'h6048);
`endif

    // Ack timeout: int_n low for exactly AckTimeout cycles, then re-request.
    reset_dut();
    set_irq(8'hFD);
    wait_int(20, ok);
    check("s5_int_low", 32'(ok), 32'd1);
    n = 0;
    while (int_n === 1'b0 && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("s5_low_cycles", 32'(n), 32'(AckTimeout));
    check("s5_released", 32'(int_n), 32'd1);
    @(negedge clk);
    check("s5_rereq", 32'(int_n), 32'd0);
    bus_read(AStatus, d);
    check("s5_status", 32'(d), 32'h0002);

    // Masked source stays silent; a one-cycle pulse of an enabled source is delivered.
    reset_dut();
    bus_write(AMask, 16'h00F7);
    set_irq(8'hF7);
    quiet(6, "s6_masked");
    set_irq(8'hE7);
    @(negedge clk);
    set_irq(8'hF7);
    service(4, 1, "s6");
    bus_read(AStatus, d);
    check("s6_status", 32'(d), 32'h1000);

    // Read and write together, unmapped address, deselected rdata.
    reset_dut();
    addr_bus = AMask; wdata = 16'h00AA; rd_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    rd_n = 1'b1; wr_n = 1'b1; m_mask = 8'hAA;
    check("s7_rdwr_old", 32'(rdata), 32'h00FF);
    @(negedge clk);
    check("s7_rdata_idle", 32'(rdata), 32'h0000);
    bus_write(AUnmapped, 16'hFFFF);
    bus_read(AUnmapped, d); check("s7_unmapped", 32'(d), 32'h0000);
    bus_read(AMask, d);     check("s7_mask_new", 32'(d), 32'h00AA);

    // EOI in the ACK cycle for the same index: the bit ends set.
    reset_dut();
    set_irq(8'hFB);
    wait_int(20, ok);
    check("s9_int_low", 32'(ok), 32'd1);
    int_ack_n = 1'b0;
    @(negedge clk);
    int_ack_n = 1'b1;
    check("s9_vv", 32'(vector_valid), 32'd1);
    addr_bus = AEoi; wdata = 16'd2; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    bus_read(AStatus, d);
`ifdef IRQ_EDGE_EN
    check("s9_status", 32'(d), 32'h0400);
`else
    check("s9_status", 32'(d), 32'h0404);
`endif

    // Reset mid-handshake.
    reset_dut();
    set_irq(8'hBF);
    service(6, 0, "s8a");
    set_irq(8'h3F);
    wait_int(20, ok);
    check("s8_int_low", 32'(ok), 32'd1);
    rst = 1'b1;
    set_irq(8'hFF);
    @(negedge clk);
    check("s8_rst_int_n", 32'(int_n), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    m_isr = '0; m_mask = 8'hFF; m_lat = '0;
    repeat (2) @(negedge clk);
    bus_read(AStatus, d);
    check("s8_status", 32'(d), 32'h0000);

    // Randomized rounds against the model.
    for (int r = 0; r < 30; r++) begin
      reset_dut();
      bus_write(AMask, 16'($urandom_range(0, 255)));
      repeat (2) @(negedge clk);
      set_irq(8'($urandom_range(0, 255)));
      for (int s = 0; s < 8; s++) begin
        if ($urandom_range(0, 2) != 0) begin
          int w;
          w = model_winner();
          if (w >= 0) service(w, int'($urandom_range(0, 4)), "rnd");
          else quiet(4, "rnd_idle");
        end else begin
          bus_write(AEoi, 16'($urandom_range(0, 7)));
        end
        bus_read(AStatus, d);
        check("rnd_status", 32'(d), 32'(model_status()));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
Interrupt arbitration and sequencing controller for the CPU bus interrupt path. Collects active-low device requests and applies a mask and in-service (ISR) tracking. Selects the highest-priority eligible source and runs the int_n/int_ack_n handshake with the CPU, presenting the vector on ack. Software configures it through three bus-mapped registers and ends service with an EOI write.

Parameters:
NUM_SRC, 8, number of request inputs; index 0 lowest priority, NUM_SRC-1 highest
BASE_ADDR, 14'h2000, 14-bit bus address of the MASK register
ACK_TIMEOUT, 255, cycles to wait for int_ack_n before abandoning a request (1..65535)

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
irq_n  input  NUM_SRC  device requests, active low, level-sensitive
int_ack_n  input  1  CPU interrupt acknowledge, active low
int_n  output  1  interrupt request to CPU, active low, registered
vector  output  8  {zero-extended winner index}, valid only while vector_valid=1
vector_valid  output  1  one-cycle strobe in the cycle after ack is sampled
addr_bus  input  14  register address
rd_n  input  1  read strobe, active low
wr_n  input  1  write strobe, active low
wdata  input  16  write data
rdata  output  16  read data, registered, 0 when not selected

Behaviour:
- Reset (sync, rst=1 at posedge): int_n=1, vector=0, vector_valid=0, rdata=0, MASK=all 1s (all enabled), ISR=0, state=IDLE, timeout counter=0, irq sample reg=all 1s.
- irq_n registered once (irq_s). pend = ~irq_s & MASK.
- Eligible = pend bits whose index > highest set ISR index (all pend bits if ISR=0). Winner = highest eligible index.
- Registers: BASE_ADDR: MASK (RW, low NUM_SRC bits). BASE_ADDR+2: EOI (W): clears ISR bit wdata[2:0] if set, else ignored. BASE_ADDR+4: STATUS (RO): {ISR[7:0], pend[7:0]}. Reads return rdata one cycle after rd_n low; unmapped addresses read 0, writes ignored.
- FSM states: IDLE, REQ, ACK.
- IDLE: if any eligible, latch winner into sel, set int_n=0, clear counter, go REQ.
- REQ: hold int_n=0. If int_ack_n=0, go ACK. Otherwise increment counter; at counter==ACK_TIMEOUT, set int_n=1 and go IDLE with no ISR change (source re-arbitrates).
- ACK: int_n=1, vector=sel, vector_valid=1 for exactly this cycle, set ISR[sel], go IDLE.
- Latency: irq_n low sampled at edge k -> int_n low after edge k+1 (IDLE) -> one cycle after int_ack_n is sampled low, vector_valid=1.
- No preemption mid-handshake: sel stays fixed in REQ even if a higher source or a MASK change arrives. A newly higher source is arbitrated in the next IDLE cycle, so nesting is allowed.
- Source deasserts during REQ: request still completes with the latched sel (spurious-vector policy is software's concern).
- EOI write and ACK in the same cycle: both apply. If the EOI index equals sel, the ISR bit ends set (set wins).
- MASK write in same cycle as IDLE arbitration: arbitration uses the old MASK.
- rd and wr asserted together: write applies, read returns pre-write value.
- rst mid-handshake: int_n=1 on the next edge, ISR cleared.

Optional Feature:
IRQ_EDGE_EN: when defined, each source latches a pending flop on a falling edge of irq_s (1->0). pend = latch & MASK. The latch clears in ACK for sel, and edges arriving during ACK for that source are retained (set wins). STATUS reports latches. When undefined, detection is level-sensitive as above with no latches.

Decomposition:
- Package irq_pkg: state enum (IDLE, REQ, ACK), register offsets (MASK_OFS=0, EOI_OFS=2, STATUS_OFS=4), VEC_W=8, max-index function.
- One sub-module: irq_prio_enc, combinational highest-set-bit encoder with threshold input (ISR top index) and any_valid output.

Test Plan:
- rst=1 for 2 cycles -> int_n=1, rdata=0; read BASE+0 -> 16'h00FF.
- irq_n=8'hFB (src 2), int_ack_n low 3 cycles after int_n falls -> vector=2, vector_valid 1 cycle, STATUS=16'h0404; EOI wdata=2 -> STATUS=16'h0004 while src held.
- irq_n=8'h7E (src 0 and 7 low) -> vector=7 first; after EOI 7 -> vector=0.
- ISR[5] set, src 3 low -> int_n stays 1; src 6 low -> int_n=0, vector=6 (nested).
- No ack for ACK_TIMEOUT=255 cycles -> int_n returns 1, ISR unchanged, re-request next cycle.
- MASK=8'hF7 with src 3 low -> no int_n; with IRQ_EDGE_EN, pulse src 4 low 1 cycle -> latched, delivered vector=4.
